// File: rtl/sevenseg_scan.sv
// sevenseg_scan: 8-digit multiplexed seven-segment scan controller with a
// frame-synchronous shadow register, anode ghost-blanking and digit masking.
// Ports: clk, rst (sync, active-high), data[31:0] + load strobe into the
// pending register, digit_en[7:0] per-digit enable; outputs digit_sel[2:0],
// nibble[3:0], an_l[7:0] (active-low anodes), frame_start (wrap pulse).
// Optional macro SEVENSEG_LZ_BLANK_EN enables leading-zero suppression.
module sevenseg_scan #(
  parameter int PRESCALE  = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data,
  input  logic        load,
  input  logic [7:0]  digit_en,
  output logic [2:0]  digit_sel,
  output logic [3:0]  nibble,
  output logic [7:0]  an_l,
  output logic        frame_start
);

  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] LAST_V  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_V = CW'(BLANK_CYC);

  logic [CW-1:0] cnt;
  logic [31:0]   shadow;
  logic [31:0]   pending;
  logic          pend_v;

  logic          last;
  logic          wrap;
  logic [CW-1:0] cnt_n;
  logic [2:0]    dig_n;
  logic [31:0]   shadow_n;
  logic          supp;
  logic          dark;
  logic [7:0]    an_n;

  // Outputs are registered from next-state values so they move on the
  // same edge as cnt/digit and reflect the shadow of the new frame.
  always_comb begin
    last     = (cnt == LAST_V);
    wrap     = last && (digit_sel == 3'd7);
    cnt_n    = last ? '0 : cnt + 1'b1;
    dig_n    = last ? digit_sel + 3'd1 : digit_sel;
    shadow_n = shadow;
    if (wrap) begin
      if (load)        shadow_n = data;
      else if (pend_v) shadow_n = pending;
    end
  end

`ifdef SEVENSEG_LZ_BLANK_EN
  // hz[k]: shadow nibbles k..7 are all zero.
  logic [7:0] hz;
  always_comb begin
    hz    = '0;
    hz[7] = (shadow_n[31:28] == 4'h0);
    for (int k = 6; k >= 0; k--)
      hz[k] = hz[k+1] && (shadow_n[4*k +: 4] == 4'h0);
    supp = (dig_n != 3'd0) && hz[dig_n];
  end
`else
  always_comb supp = 1'b0;
`endif

  always_comb begin
    dark = (cnt_n < BLANK_V) || !digit_en[dig_n] || supp;
    an_n = dark ? 8'hFF : ~(8'b1 << dig_n);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      digit_sel   <= '0;
      nibble      <= '0;
      an_l        <= 8'hFF;
      frame_start <= 1'b0;
      shadow      <= '0;
      pending     <= '0;
      pend_v      <= 1'b0;
    end else begin
      cnt         <= cnt_n;
      digit_sel   <= dig_n;
      shadow      <= shadow_n;
      nibble      <= shadow_n[4*dig_n +: 4];
      an_l        <= an_n;
      frame_start <= wrap;
      // A load on the wrap edge bypasses straight into the shadow.
      if (wrap) begin
        pend_v <= 1'b0;
      end else if (load) begin
        pending <= data;
        pend_v  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan.sv
// Directed bench for sevenseg_scan (PRESCALE=4, BLANK_CYC=1).
// cyc 0 is the cnt=0 digit-0 cycle; cnt=cyc%4, digit=(cyc/4)%8.
module tb_sevenseg_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data;
  logic        load;
  logic [7:0]  digit_en;
  logic [2:0]  digit_sel;
  logic [3:0]  nibble;
  logic [7:0]  an_l;
  logic        frame_start;

  int total = 0;
  int fails = 0;
  int cyc   = 0;
  int fs_count = 0;

  sevenseg_scan #(.PRESCALE(4), .BLANK_CYC(1)) dut (
    .clk(clk), .rst(rst), .data(data), .load(load),
    .digit_en(digit_en), .digit_sel(digit_sel), .nibble(nibble),
    .an_l(an_l), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (frame_start === 1'b1) fs_count++;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic adv_to(input int t);
    while (cyc < t) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; data = '0; digit_en = 8'hFF;

    // reset held three cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_an", an_l, 8'hFF);
      chk("rst_sel", digit_sel, 3'd0);
      chk("rst_fs", frame_start, 1'b0);
      chk("rst_nib", nibble, 4'h0);
    end
    cyc = 0;
    rst = 1'b0;

    adv_to(1); chk("seq1_an", an_l, 8'hFE); chk("seq1_sel", digit_sel, 3'd0);
    adv_to(2); chk("seq2_an", an_l, 8'hFE);
    adv_to(3); chk("seq3_an", an_l, 8'hFE); chk("seq3_sel", digit_sel, 3'd0);
    adv_to(4); chk("seq4_an", an_l, 8'hFF); chk("seq4_sel", digit_sel, 3'd1);
    adv_to(5); chk("seq5_an", an_l, 8'hFD);

    // tear-free: load mid-frame during digit 3
    adv_to(13); data = 32'h1234_5678; load = 1'b1;
    adv_to(14); load = 1'b0;
    chk("tf_nib14", nibble, 4'h0);
    adv_to(20); chk("tf_nib20", nibble, 4'h0);
    adv_to(31); chk("tf_nib31", nibble, 4'h0);
    chk("tf_fs_none", fs_count, 0);
    adv_to(32); chk("tf_fs", frame_start, 1'b1); chk("tf_d0", nibble, 4'h8);
    chk("tf_sel0", digit_sel, 3'd0);
    adv_to(33); chk("tf_fs_off", frame_start, 1'b0);

    // last load wins
    adv_to(40); data = 32'hAAAA_AAAA; load = 1'b1;
    adv_to(41); load = 1'b0;
    adv_to(50); data = 32'h0000_00FF; load = 1'b1;
    adv_to(51); load = 1'b0;
    adv_to(52); chk("llw_hold", nibble, 4'h3);
    adv_to(60); chk("tf_d7", nibble, 4'h1);
    adv_to(64); chk("fs_once", fs_count, 1);
    chk("llw_d0", nibble, 4'hF);
    adv_to(68); chk("llw_d1", nibble, 4'hF);
    adv_to(72); chk("llw_d2", nibble, 4'h0);
    adv_to(92); chk("llw_d7", nibble, 4'h0);

    // load on wrap edge bypasses into the new frame
    adv_to(95); data = 32'hCAFE_0001; load = 1'b1;
    adv_to(96); load = 1'b0;
    chk("wrap_d0", nibble, 4'h1); chk("wrap_fs", frame_start, 1'b1);
    adv_to(100); chk("wrap_d1", nibble, 4'h0);
    adv_to(112); chk("wrap_d4", nibble, 4'hE);
    adv_to(124); chk("wrap_d7", nibble, 4'hC);
    adv_to(128); chk("wrap_nopend", nibble, 4'h1);

    // digit mask, pending load then mid-frame reset
    digit_en = 8'h0F;
    adv_to(137); chk("mask_d2", an_l, 8'hFB);
    adv_to(140); data = 32'h7777_7777; load = 1'b1;
    adv_to(141); load = 1'b0;
    adv_to(145); chk("mask_d4a", an_l, 8'hFF); chk("mask_s4", digit_sel, 3'd4);
    adv_to(147); chk("mask_d4c", an_l, 8'hFF);
    adv_to(149); chk("mask_d5", an_l, 8'hFF); chk("mask_s5", digit_sel, 3'd5);
    adv_to(150); rst = 1'b1;
    adv_to(151);
    chk("mrst_sel", digit_sel, 3'd0); chk("mrst_an", an_l, 8'hFF);
    chk("mrst_nib", nibble, 4'h0); chk("mrst_fs", frame_start, 1'b0);
    cyc = 0; rst = 1'b0;
    adv_to(1); chk("mrst_c1_an", an_l, 8'hFE);
    adv_to(16); chk("mrst_d4_nib", nibble, 4'h0);
    adv_to(17); chk("mrst_d4_an", an_l, 8'hFF);
    adv_to(32); chk("mrst_fs", frame_start, 1'b1);
    chk("mrst_discard", nibble, 4'h0);

    // leading zeros
    digit_en = 8'hFF;
    adv_to(33); data = 32'h0000_00A0; load = 1'b1;
    adv_to(34); load = 1'b0;
    adv_to(65); chk("lz_d0", an_l, 8'hFE); chk("lz_n0", nibble, 4'h0);
    adv_to(69); chk("lz_d1", an_l, 8'hFD); chk("lz_n1", nibble, 4'hA);
    adv_to(70); data = 32'h0; load = 1'b1;
    adv_to(71); load = 1'b0;
`ifdef SEVENSEG_LZ_BLANK_EN
    adv_to(73); chk("lz_d2", an_l, 8'hFF);
    adv_to(93); chk("lz_d7", an_l, 8'hFF);
    adv_to(97); chk("z_d0", an_l, 8'hFE); chk("z_n0", nibble, 4'h0);
    adv_to(101); chk("z_d1", an_l, 8'hFF);
`else
    adv_to(73); chk("lz_d2", an_l, 8'hFB);
    adv_to(93); chk("lz_d7", an_l, 8'h7F);
    adv_to(97); chk("z_d0", an_l, 8'hFE); chk("z_n0", nibble, 4'h0);
    adv_to(101); chk("z_d1", an_l, 8'hFD);
`endif

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
